// File: rtl/i2c_pkg.sv
// i2c master shared package: FSM state codes,
// bus constants and the address-byte helper.
package i2c_pkg;

  localparam logic [6:0] I2C_DEV_ADDR = 7'h68;
  localparam logic       I2C_RW_WR    = 1'b0;
  localparam logic       I2C_RW_RD    = 1'b1;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_START  = 4'd1;
  localparam logic [3:0] ST_ADDR_W = 4'd2;
  localparam logic [3:0] ST_ACK_A  = 4'd3;
  localparam logic [3:0] ST_REG    = 4'd4;
  localparam logic [3:0] ST_ACK_R  = 4'd5;
  localparam logic [3:0] ST_WDATA  = 4'd6;
  localparam logic [3:0] ST_ACK_D  = 4'd7;
  localparam logic [3:0] ST_RSTART = 4'd8;
  localparam logic [3:0] ST_ADDR_R = 4'd9;
  localparam logic [3:0] ST_ACK_AR = 4'd10;
  localparam logic [3:0] ST_RDATA  = 4'd11;
  localparam logic [3:0] ST_MNACK  = 4'd12;
  localparam logic [3:0] ST_STOP   = 4'd13;
  localparam logic [3:0] ST_DONE   = 4'd14;

  function automatic logic [7:0] addr_byte(
    input logic [6:0] addr,
    input logic       rw
  );
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_master_ctrl.sv
// i2c register-access master FSM (write / read via repeated START).
// Ports: CLK, RST_n; I_SCL + mid-low/mid-high strobes from the divider;
// I_START/I_RW/I_REG_ADDR/I_WR_DATA request; I_SDA line level;
// O_SDA_LOW/O_SCL_LOW open-drain pulls; O_BUSY, O_DONE, O_ACK_ERR,
// O_RD_DATA status.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = I2C_DEV_ADDR,
  parameter int         BIT_CNT_W = 3
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       I_SCL,
  input  logic       I_RS_PR_SCL,
  input  logic       I_FL_PR_SCL,
  input  logic       I_START,
  input  logic       I_RW,
  input  logic [7:0] I_REG_ADDR,
  input  logic [7:0] I_WR_DATA,
  input  logic       I_SDA,
  output logic       O_SDA_LOW,
  output logic       O_SCL_LOW,
  output logic       O_BUSY,
  output logic       O_DONE,
  output logic       O_ACK_ERR,
  output logic [7:0] O_RD_DATA
);

  localparam logic [BIT_CNT_W-1:0] CNT_LAST = '1;

  logic [3:0]           state;
  logic [3:0]           ack_nxt;
  logic                 is_tx;
  logic                 is_ack;
  logic                 rw_q;
  logic [7:0]           reg_q;
  logic [7:0]           wd_q;
  logic [7:0]           tx_q;
  logic [7:0]           rx_q;
  logic [BIT_CNT_W-1:0] cnt_q;
  logic                 nack_q;
  logic                 scl_en_q;
  logic                 sda_low_q;
  logic                 busy_q;
  logic                 ack_err_q;
  logic [7:0]           rd_q;

  always_comb begin
    is_tx   = 1'b0;
    is_ack  = 1'b0;
    ack_nxt = ST_ACK_D;
    unique case (state)
      ST_ADDR_W: begin
        is_tx   = 1'b1;
        ack_nxt = ST_ACK_A;
      end
      ST_REG: begin
        is_tx   = 1'b1;
        ack_nxt = ST_ACK_R;
      end
      ST_WDATA: begin
        is_tx   = 1'b1;
        ack_nxt = ST_ACK_D;
      end
      ST_ADDR_R: begin
        is_tx   = 1'b1;
        ack_nxt = ST_ACK_AR;
      end
      ST_ACK_A, ST_ACK_R,
      ST_ACK_D, ST_ACK_AR: is_ack = 1'b1;
      default: ack_nxt = ST_ACK_D;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= ST_IDLE;
      rw_q      <= 1'b0;
      reg_q     <= 8'h00;
      wd_q      <= 8'h00;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      cnt_q     <= '0;
      nack_q    <= 1'b0;
      scl_en_q  <= 1'b0;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rd_q      <= 8'h00;
    end else begin
      // SCL gating latches on at the first mid-low after START
      if (I_RS_PR_SCL && state != ST_IDLE &&
          state != ST_START && state != ST_DONE)
        scl_en_q <= 1'b1;
      if (is_ack && I_RS_PR_SCL)
        sda_low_q <= 1'b0;
      if (is_ack && I_FL_PR_SCL && I_SDA)
        nack_q <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (I_START) begin
            rw_q      <= I_RW;
            reg_q     <= I_REG_ADDR;
            wd_q      <= I_WR_DATA;
            busy_q    <= 1'b1;
            ack_err_q <= 1'b0;
            nack_q    <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (I_FL_PR_SCL) begin
            sda_low_q <= 1'b1;
            tx_q  <= addr_byte(DEV_ADDR, I2C_RW_WR);
            cnt_q <= '0;
            state <= ST_ADDR_W;
          end
        end
        ST_ADDR_W, ST_REG,
        ST_WDATA, ST_ADDR_R: begin
          if (I_RS_PR_SCL) begin
            sda_low_q <= ~tx_q[7];
            tx_q      <= {tx_q[6:0], 1'b0};
          end
          if (I_FL_PR_SCL) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST)
              state <= ack_nxt;
          end
        end
        ST_ACK_A: begin
          if (I_FL_PR_SCL) begin
            tx_q  <= reg_q;
            state <= ST_REG;
          end
        end
        ST_ACK_R: begin
          if (I_FL_PR_SCL) begin
            tx_q  <= wd_q;
            state <= rw_q ? ST_RSTART : ST_WDATA;
          end
        end
        ST_ACK_D: begin
          if (I_FL_PR_SCL)
            state <= ST_STOP;
        end
        ST_ACK_AR: begin
          if (I_FL_PR_SCL)
            state <= ST_RDATA;
        end
        ST_RSTART: begin
          if (I_RS_PR_SCL)
            sda_low_q <= 1'b0;
          if (I_FL_PR_SCL) begin
            sda_low_q <= 1'b1;
            tx_q  <= addr_byte(DEV_ADDR, I2C_RW_RD);
            state <= ST_ADDR_R;
          end
        end
        ST_RDATA: begin
          if (I_RS_PR_SCL)
            sda_low_q <= 1'b0;
          if (I_FL_PR_SCL) begin
            rx_q  <= {rx_q[6:0], I_SDA};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST)
              state <= ST_MNACK;
          end
        end
        ST_MNACK: begin
          if (I_RS_PR_SCL)
            sda_low_q <= 1'b0;
          if (I_FL_PR_SCL)
            state <= ST_STOP;
        end
        ST_STOP: begin
          if (I_RS_PR_SCL)
            sda_low_q <= 1'b1;
          if (I_FL_PR_SCL) begin
            sda_low_q <= 1'b0;
            scl_en_q  <= 1'b0;
            ack_err_q <= nack_q;
            if (rw_q)
              rd_q <= rx_q;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // the strobe term pulls SCL low in the very cycle the first bit is
  // scheduled, so SCL is already low when SDA moves a cycle later
  assign O_SCL_LOW = ~I_SCL &
    (scl_en_q | (I_RS_PR_SCL & is_tx & (state == ST_ADDR_W)));
  assign O_SDA_LOW = sda_low_q;
  assign O_BUSY    = busy_q;
  assign O_DONE    = (state == ST_DONE);
  assign O_ACK_ERR = ack_err_q;
  assign O_RD_DATA = rd_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus-level slave model decodes tokens,
// scoreboard queues hold expected tokens and DONE results.
module tb_i2c_master_ctrl;

  localparam logic [6:0] DEV = 7'h68;
  localparam int T_S  = 1;
  localparam int T_SR = 2;
  localparam int T_P  = 3;
  localparam int T_B  = 4;

  typedef struct {
    logic       ack;
    logic [7:0] rd;
  } res_t;

  logic       CLK;
  logic       RST_n;
  logic       I_SCL;
  logic       I_RS_PR_SCL;
  logic       I_FL_PR_SCL;
  logic       I_START;
  logic       I_RW;
  logic [7:0] I_REG_ADDR;
  logic [7:0] I_WR_DATA;
  logic       I_SDA;
  logic       O_SDA_LOW;
  logic       O_SCL_LOW;
  logic       O_BUSY;
  logic       O_DONE;
  logic       O_ACK_ERR;
  logic [7:0] O_RD_DATA;

  logic        slave_low;
  logic        slave_present;
  logic [7:0]  slave_byte;
  logic [31:0] exp_tok[$];
  res_t        exp_res[$];
  logic [7:0]  last_rd;

  int tests, fails, done_cnt, race_cnt, n_res;
  int dcnt, bitcnt, byte_idx, hold;
  logic [7:0] sh;
  logic scl_q, sda_q, addr_rw, in_txn;

  assign I_SDA = ~(O_SDA_LOW | slave_low);

  i2c_master_ctrl dut (
    .CLK(CLK), .RST_n(RST_n), .I_SCL(I_SCL),
    .I_RS_PR_SCL(I_RS_PR_SCL), .I_FL_PR_SCL(I_FL_PR_SCL),
    .I_START(I_START), .I_RW(I_RW), .I_REG_ADDR(I_REG_ADDR),
    .I_WR_DATA(I_WR_DATA), .I_SDA(I_SDA), .O_SDA_LOW(O_SDA_LOW),
    .O_SCL_LOW(O_SCL_LOW), .O_BUSY(O_BUSY), .O_DONE(O_DONE),
    .O_ACK_ERR(O_ACK_ERR), .O_RD_DATA(O_RD_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 16-cycle SCL: high 0..7, mid-high strobe at 4, mid-low at 12
  initial begin
    dcnt = 0; I_SCL = 1'b1;
    I_FL_PR_SCL = 1'b0; I_RS_PR_SCL = 1'b0;
    forever begin
      @(negedge CLK);
      dcnt = (dcnt + 1) % 16;
      I_SCL = (dcnt < 8);
      I_FL_PR_SCL = (dcnt == 4);
      I_RS_PR_SCL = (dcnt == 12);
    end
  end

  function automatic logic [31:0] tok(input int t, input logic [7:0] b,
                                      input logic a);
    return (32'(t) << 16) | {16'd0, b, 7'd0, a};
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_tok(input logic [31:0] got);
    if (exp_tok.size() == 0) check("bus_token_extra", got, 0);
    else check("bus_token", got, exp_tok.pop_front());
  endtask

  task automatic bus_step(input logic at_pos);
    logic scl, sda, rd_mode;
    res_t r;
    scl = ~O_SCL_LOW;
    sda = I_SDA;
    if (!RST_n) begin
      bitcnt = 0; byte_idx = 0; in_txn = 1'b0;
      slave_low = 1'b0; hold = 2;
    end else if (hold > 0) begin
      hold--;
    end else begin
      if (scl != scl_q && sda != sda_q) race_cnt++;
      if (scl && scl_q && sda != sda_q) begin
        bitcnt = 0;
        if (!sda) begin
          cmp_tok(tok(in_txn ? T_SR : T_S, 8'h00, 1'b0));
          in_txn = 1'b1; byte_idx = 0;
        end else begin
          cmp_tok(tok(T_P, 8'h00, 1'b0));
          in_txn = 1'b0;
        end
      end else if (scl && !scl_q) begin
        if (bitcnt < 8) begin
          sh = {sh[6:0], sda}; bitcnt++;
        end else begin
          cmp_tok(tok(T_B, sh, sda));
          if (byte_idx == 0) addr_rw = sh[0];
          byte_idx++; bitcnt = 0;
        end
      end else if (!scl && scl_q) begin
        rd_mode = (byte_idx == 1) && addr_rw;
        if (bitcnt == 8) slave_low = slave_present && !rd_mode;
        else if (rd_mode && slave_present)
          slave_low = ~slave_byte[7 - bitcnt];
        else slave_low = 1'b0;
      end
    end
    scl_q = scl; sda_q = sda;
    if (at_pos && RST_n && O_DONE) begin
      done_cnt++;
      if (exp_res.size() == 0) begin
        check("done_extra", done_cnt, n_res);
      end else begin
        r = exp_res.pop_front();
        check("ack_err", O_ACK_ERR, r.ack);
        check("rd_data", O_RD_DATA, r.rd);
        check("tokens_left", exp_tok.size(), 0);
      end
    end
  endtask

  initial begin
    scl_q = 1'b1; sda_q = 1'b1; slave_low = 1'b0;
    bitcnt = 0; byte_idx = 0; hold = 2; sh = 8'h00;
    addr_rw = 1'b0; in_txn = 1'b0;
    forever begin
      @(posedge CLK); #1; bus_step(1'b1);
      @(negedge CLK); #1; bus_step(1'b0);
    end
  end

  task automatic push_addr_reg(input logic [7:0] ra, input logic a);
    exp_tok.push_back(tok(T_S, 8'h00, 1'b0));
    exp_tok.push_back(tok(T_B, {DEV, 1'b0}, a));
    exp_tok.push_back(tok(T_B, ra, a));
  endtask

  task automatic issue(input logic rw, input logic [7:0] ra,
                       input logic [7:0] wd);
    @(negedge CLK);
    I_START = 1'b1; I_RW = rw; I_REG_ADDR = ra; I_WR_DATA = wd;
    @(negedge CLK);
    I_START = 1'b0; I_RW = 1'($urandom);
    I_REG_ADDR = 8'($urandom); I_WR_DATA = 8'($urandom);
  endtask

  task automatic run_txn(input logic rw, input logic [7:0] ra,
                         input logic [7:0] wd, input logic [7:0] sb,
                         input logic pres, input logic poke);
    logic [7:0] rv;
    int d0, n;
    slave_present = pres; slave_byte = sb;
    rv = pres ? sb : 8'hFF;
    push_addr_reg(ra, !pres);
    if (!rw) begin
      exp_tok.push_back(tok(T_B, wd, !pres));
    end else begin
      exp_tok.push_back(tok(T_SR, 8'h00, 1'b0));
      exp_tok.push_back(tok(T_B, {DEV, 1'b1}, !pres));
      exp_tok.push_back(tok(T_B, rv, 1'b1));
      last_rd = rv;
    end
    exp_tok.push_back(tok(T_P, 8'h00, 1'b0));
    exp_res.push_back('{ack: !pres, rd: last_rd});
    n_res++;
    d0 = done_cnt;
    issue(rw, ra, wd);
    check("busy_after_start", O_BUSY, 1);
    if (poke) begin
      repeat (100) @(negedge CLK);
      I_START = 1'b1; I_RW = ~rw; I_REG_ADDR = ~ra;
      @(negedge CLK);
      I_START = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge CLK); n++;
    end
    repeat (40) @(negedge CLK);
    check("done_count", done_cnt - d0, 1);
    check("idle_busy", O_BUSY, 0);
  endtask

  initial begin
    tests = 0; fails = 0; done_cnt = 0; race_cnt = 0; n_res = 0;
    last_rd = 8'h00;
    RST_n = 1'b0; I_START = 1'b0; I_RW = 1'b0;
    I_REG_ADDR = 8'h00; I_WR_DATA = 8'h00;
    slave_present = 1'b1; slave_byte = 8'h00;
    repeat (4) @(negedge CLK);
    check("rst_sda_low", O_SDA_LOW, 0);
    check("rst_scl_low", O_SCL_LOW, 0);
    check("rst_busy", O_BUSY, 0);
    check("rst_done", O_DONE, 0);
    check("rst_ack_err", O_ACK_ERR, 0);
    check("rst_rd_data", O_RD_DATA, 0);
    RST_n = 1'b1;
    repeat (20) @(negedge CLK);

    run_txn(1'b0, 8'h6B, 8'h00, 8'h00, 1'b1, 1'b0);
    run_txn(1'b1, 8'h75, 8'h00, 8'h68, 1'b1, 1'b0);
    run_txn(1'b0, 8'h3C, 8'h5A, 8'h00, 1'b0, 1'b0);
    run_txn(1'b1, 8'h75, 8'h00, 8'h68, 1'b0, 1'b0);
    run_txn(1'b0, 8'h10, 8'hA5, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++)
      run_txn(1'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), $urandom_range(3) != 0, 1'b0);

    // reset in the middle of the register byte
    slave_present = 1'b1;
    push_addr_reg(8'h6B, 1'b0);
    void'(exp_tok.pop_back());
    issue(1'b0, 8'h6B, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      if (in_txn && byte_idx == 1 && bitcnt == 3) break;
      @(negedge CLK);
    end
    @(negedge CLK); #2;
    RST_n = 1'b0;
    #1;
    check("midrst_sda_low", O_SDA_LOW, 0);
    check("midrst_scl_low", O_SCL_LOW, 0);
    check("midrst_busy", O_BUSY, 0);
    check("midrst_tokens", exp_tok.size(), 0);
    exp_tok.delete();
    exp_res.delete();
    last_rd = 8'h00;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    check("midrst_rd_data", O_RD_DATA, last_rd);
    repeat (20) @(negedge CLK);
    run_txn(1'b0, 8'h6B, 8'h00, 8'h00, 1'b1, 1'b0);

    check("bus_sda_scl_race", race_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 Parameter DEV_ADDR, default 7'h68, meaning 7-bit slave address placed in every address phase.
REQ-002 Parameter BIT_CNT_W, default 3, meaning width of the bit-within-byte counter.
REQ-003 CLK  input  1  system clock, 50 MHz; single clock domain.
REQ-004 RST_n  input  1  reset, asynchronous, active-low.
REQ-005 I_SCL  input  1  free-running serial clock from the i2c clock divider.
REQ-006 I_RS_PR_SCL  input  1  one-cycle strobe at mid-low of I_SCL; the only SDA drive point.
REQ-007 I_FL_PR_SCL  input  1  one-cycle strobe at mid-high of I_SCL; the SDA sample point and START/STOP point.
REQ-008 I_START  input  1  transaction request, sampled only in IDLE.
REQ-009 I_RW  input  1  0 = register write, 1 = register read; captured with I_START.
REQ-010 I_REG_ADDR  input  8  target register address; captured with I_START.
REQ-011 I_WR_DATA  input  8  write payload; captured with I_START.
REQ-012 I_SDA  input  1  synchronised SDA line level.
REQ-013 O_SDA_LOW  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-014 O_SCL_LOW  output  1  1 = pull SCL low; 0 = release.
REQ-015 O_BUSY  output  1  high from accepted I_START until DONE.
REQ-016 O_DONE  output  1  one-cycle pulse at transaction end.
REQ-017 O_ACK_ERR  output  1  set with O_DONE if any slave ACK was missing; held until the next accepted I_START.
REQ-018 O_RD_DATA  output  8  byte read from the slave; valid from O_DONE until the next accepted I_START.

Function
REQ-019 FSM states: IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D, RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP, DONE.
REQ-020 IDLE: O_SDA_LOW=0, O_SCL_LOW=0, O_BUSY=0; I_START=1 latches inputs, sets O_BUSY next cycle, clears O_ACK_ERR, enters START.
REQ-021 START waits for I_FL_PR_SCL, then asserts O_SDA_LOW (SDA falls while SCL high) and enters ADDR_W.
REQ-022 From the first I_RS_PR_SCL after START until STOP completes, O_SCL_LOW = NOT I_SCL.
REQ-023 Byte-transmit states (ADDR_W={DEV_ADDR,0}, REG, WDATA, ADDR_R={DEV_ADDR,1}) drive bits MSB first, one per I_RS_PR_SCL, O_SDA_LOW = NOT bit; a bit counter advances on each I_FL_PR_SCL; after 8 I_FL_PR_SCL strobes the FSM enters the following ACK state.
REQ-024 ACK states release SDA at I_RS_PR_SCL and sample I_SDA at I_FL_PR_SCL; I_SDA=1 sets an internal NACK flag; the transaction always continues (no early abort).
REQ-025 Sequence for write: START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D, STOP.
REQ-026 Sequence for read: START, ADDR_W, ACK_A, REG, ACK_R, RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP.
REQ-027 RSTART: release SDA at I_RS_PR_SCL, pull SDA low at the next I_FL_PR_SCL (repeated START), then enter ADDR_R.
REQ-028 RDATA: SDA released; I_SDA shifted in MSB first at each I_FL_PR_SCL; 8 bits.
REQ-029 MNACK: SDA released for one full SCL period (master NACK).
REQ-030 STOP: pull SDA low at I_RS_PR_SCL; at the next I_FL_PR_SCL release SDA (SDA rises while SCL high) and stop driving SCL; enter DONE.
REQ-031 DONE lasts one cycle: O_DONE=1, O_ACK_ERR=NACK flag, O_RD_DATA updated (reads only), then IDLE.
REQ-032 I_START outside IDLE is ignored; request-to-first-SCL-low latency is at most one SCL period plus 2 CLK cycles.
REQ-033 I_RS_PR_SCL and I_FL_PR_SCL are never simultaneous; on a simultaneous I_FL_PR_SCL and state exit, the FSM takes the exit.

Reset
REQ-034 RST_n low asynchronously forces IDLE, all outputs to 0, O_RD_DATA to 8'h00 and the counters and flags cleared, including mid-transaction (bus released).

Structure
REQ-035 State encodings and I2C constants (DEV_ADDR default, RW bit values) belong in the shared i2c package.
REQ-036 The controller instantiates i2c_clk_div (FPGA_CLK=50_000_000, I2C_CLK=100_000) as its one sub-module, or receives its three outputs as ports in a wrapper; the FSM itself is one module.

Verification
REQ-037 Write: I_RW=0, reg 8'h6B, data 8'h00, slave ACKs all -> SDA bytes D0, 6B, 00, STOP, O_DONE=1, O_ACK_ERR=0.
REQ-038 Read: I_RW=1, reg 8'h75, slave returns 8'h68 -> bytes D0, 75, Sr, D1, master NACK, STOP, O_RD_DATA=8'h68.
REQ-039 No slave (SDA always high) -> full sequence completes, O_ACK_ERR=1, O_DONE one pulse.
REQ-040 RST_n low during REG byte -> O_SDA_LOW=0, O_SCL_LOW=0, O_BUSY=0 immediately; next I_START runs a clean write.
REQ-041 I_START pulsed while O_BUSY=1 -> ignored; exactly one O_DONE pulse.
REQ-042 Bus monitor: SDA changes only while SCL low, except START/Sr/STOP edges, across all scenarios.
